// File: rtl/dmux4way16_router_if.sv
// Producer-side and consumer-side signal bundle for the 1-to-4 word router.
interface dmux4way16_router_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [1:0]             in_sel;
  logic                   in_bcast;
  logic [3:0]             out_valid;
  logic [3:0]             out_ready;
  logic [WIDTH-1:0]       out_a;
  logic [WIDTH-1:0]       out_b;
  logic [WIDTH-1:0]       out_c;
  logic [WIDTH-1:0]       out_d;
  logic [4*CNT_WIDTH-1:0] lane_count;

  // Router side
  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_a, out_b, out_c, out_d, lane_count
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_c, out_d, lane_count
  );
endinterface

// File: rtl/dmux4way16_router.sv
// Registered 1-to-4 distributor: unicast by select or all-or-nothing broadcast into
// four single-entry lanes, each with its own handshake and wrapping delivery counter.
module dmux4way16_router #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  dmux4way16_router_if.slave bus
);

  logic [WIDTH-1:0]     r_data  [4];
  logic [3:0]           r_valid;
  logic [CNT_WIDTH-1:0] r_count [4];

  logic [3:0] w_can;
  logic [3:0] w_push;
  logic [3:0] w_pop;
  logic       w_ready;
  logic       w_accept;

  assign w_can = ~r_valid | bus.out_ready;
  assign w_pop = r_valid & bus.out_ready;

  always_comb begin
    w_ready = 1'b0;
    if (!rst) begin
      w_ready = bus.in_bcast ? (&w_can) : w_can[bus.in_sel];
    end
  end

  assign w_accept = bus.in_valid & w_ready;

  always_comb begin
    w_push = 4'b0000;
    if (w_accept) begin
      w_push = bus.in_bcast ? 4'b1111 : (4'b0001 << bus.in_sel);
    end
  end

  // Push wins over pop so a full lane can stream one word per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        r_data[k]  <= '0;
        r_count[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_push[k]) begin
          r_data[k]  <= bus.in_data;
          r_valid[k] <= 1'b1;
        end else if (w_pop[k]) begin
          r_valid[k] <= 1'b0;
        end
        if (w_pop[k]) begin
          r_count[k] <= r_count[k] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.out_valid  = r_valid;
  assign bus.out_a      = r_data[0];
  assign bus.out_b      = r_data[1];
  assign bus.out_c      = r_data[2];
  assign bus.out_d      = r_data[3];
  assign bus.lane_count = {r_count[3], r_count[2], r_count[1], r_count[0]};

endmodule

// File: tb/tb_dmux4way16_router.sv
// Directed plus randomized checks of the 1-to-4 router against a lane-level reference model.
module tb_dmux4way16_router;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Reference model: what each lane holds, whether it is full, how many words it delivered
  bit          m_full [4];
  logic [15:0] m_word [4];
  int          m_sent [4];

  dmux4way16_router_if #(.WIDTH(16), .CNT_WIDTH(8)) bus ();

  dmux4way16_router #(.WIDTH(16), .CNT_WIDTH(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    bit free [4];
    for (int k = 0; k < 4; k++) free[k] = !m_full[k] || bus.out_ready[k];
    if (rst) return 1'b0;
    if (bus.in_bcast) return free[0] && free[1] && free[2] && free[3];
    return free[bus.in_sel];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 1'b0;
      m_word[k] = 16'h0000;
      m_sent[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit take;
    take = bus.in_valid && model_ready();
    for (int k = 0; k < 4; k++) begin
      bit hit;
      bit leave;
      hit   = take && (bus.in_bcast || int'(bus.in_sel) == k);
      leave = m_full[k] && bus.out_ready[k];
      if (leave) m_sent[k] = (m_sent[k] + 1) % 256;
      if (hit) begin
        m_word[k] = bus.in_data;
        m_full[k] = 1'b1;
      end else if (leave) begin
        m_full[k] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0]  ev;
    logic [31:0] ec;
    for (int k = 0; k < 4; k++) begin
      ev[k]          = m_full[k];
      ec[k*8 +: 8]   = m_sent[k][7:0];
    end
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
    chk({tag, ".out_a"}, 32'(bus.out_a), 32'(m_word[0]));
    chk({tag, ".out_b"}, 32'(bus.out_b), 32'(m_word[1]));
    chk({tag, ".out_c"}, 32'(bus.out_c), 32'(m_word[2]));
    chk({tag, ".out_d"}, 32'(bus.out_d), 32'(m_word[3]));
    chk({tag, ".lane_count"}, bus.lane_count, ec);
  endtask

  // Inputs are set by the caller; check in_ready, clock once, check the lanes.
  task automatic cycle(input string tag);
    #1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(model_ready()));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input bit b, input logic [15:0] d,
                       input logic [3:0] r);
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_bcast  = b;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_clear();
    rst = 1'b1;
    drive(1'b1, 2'd2, 1'b0, 16'h1234, 4'b0000);

    // Reset state
    #2;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
    check_outputs("rst");
    #10;
    rst = 1'b0;

    // Unicast to lane c
    cycle("uni_c");
    chk("uni_c.valid_const", 32'(bus.out_valid), 32'h4);
    chk("uni_c.data_const", 32'(bus.out_c), 32'h1234);
    bus.in_sel = 2'd2;
    #1;
    chk("ready_sel2", 32'(bus.in_ready), 32'd0);
    bus.in_sel = 2'd0;
    #1;
    chk("ready_sel0", 32'(bus.in_ready), 32'd1);

    // Pop lane c once
    drive(1'b0, 2'd2, 1'b0, 16'h0000, 4'b0100);
    cycle("pop_c");
    chk("pop_c.count_const", bus.lane_count, 32'h0001_0000);

    // Streaming on lane b
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 2'd1, 1'b0, 16'(i), 4'b0010);
      cycle("stream_b");
    end
    drive(1'b0, 2'd1, 1'b0, 16'h0000, 4'b0010);
    cycle("drain_b");
    chk("drain_b.count_const", 32'(bus.lane_count[15:8]), 32'd16);

    // Broadcast blocked by full lane d, then released
    drive(1'b1, 2'd3, 1'b0, 16'h5555, 4'b0000);
    cycle("fill_d");
    drive(1'b1, 2'd0, 1'b1, 16'hBEEF, 4'b0000);
    cycle("bcast_blocked");
    chk("bcast_blocked.valid_const", 32'(bus.out_valid), 32'h8);
    drive(1'b1, 2'd0, 1'b1, 16'hBEEF, 4'b1000);
    cycle("bcast_go");
    chk("bcast_go.valid_const", 32'(bus.out_valid), 32'hF);
    chk("bcast_go.a_const", 32'(bus.out_a), 32'hBEEF);
    chk("bcast_go.d_count_const", 32'(bus.lane_count[31:24]), 32'd1);

    // Counter wrap on lane a: push and pop every cycle
    for (int i = 1; i <= 256; i++) begin
      drive(1'b1, 2'd0, 1'b0, 16'(i), 4'b0001);
      cycle("wrap_a");
      if (i == 255) chk("wrap_a.255", 32'(bus.lane_count[7:0]), 32'd255);
    end
    chk("wrap_a.0", 32'(bus.lane_count[7:0]), 32'd0);

    // Reset between edges with every lane full
    drive(1'b1, 2'd0, 1'b1, 16'hA5A5, 4'b1111);
    cycle("fill_all");
    drive(1'b0, 2'd0, 1'b0, 16'h0000, 4'b0000);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    chk("midrst.in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst.valid_const", 32'(bus.out_valid), 32'd0);
    chk("midrst.count_const", bus.lane_count, 32'd0);
    check_outputs("midrst");
    #1;
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom));
      cycle("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmux4way16_router.md
Name: dmux4way16_router

Overview:
- Registered 1-to-4 distributor; the counterpart of the 4-way 16-bit selector.
- Accepts one 16-bit word per cycle on a valid/ready input and routes it to output lane a, b, c or d by a 2-bit select, or to all four lanes at once (broadcast).
- Each lane has a single-entry holding register with its own valid/ready handshake, and a wrapping delivered-word counter.
- Sits between one producer (e.g. ALU/CPU result bus) and four independent consumers.

Parameters:
- WIDTH, 16, data word width.
- CNT_WIDTH, 8, width of each per-lane delivered-word counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer presents a word.
- in_ready  out  1  router accepts the word this cycle (combinational).
- in_data  in  WIDTH  word to route.
- in_sel  in  2  target lane: 0=a, 1=b, 2=c, 3=d; ignored when in_bcast=1.
- in_bcast  in  1  route the word to all four lanes.
- out_valid  out  4  per-lane holding register full; bit0=a … bit3=d.
- out_ready  in  4  per-lane consumer ready; same bit order.
- out_a, out_b, out_c, out_d  out  WIDTH  lane holding registers.
- lane_count  out  4*CNT_WIDTH  delivered counters; lane a at [CNT_WIDTH-1:0], then b, c, d.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - out_valid=0, out_a..out_d=0, lane_count=0.
  - in_ready=0 while rst is high.
  - Words held at reset are discarded and not counted.
- Lane k can take a word when !out_valid[k] | out_ready[k]. Call this can_k.
- in_ready:
  - in_bcast=0: equals can of lane in_sel.
  - in_bcast=1: equals can_a & can_b & can_c & can_d.
  - Depends combinationally on out_ready; no state.
- Accept: the cycle where in_valid & in_ready. Push affects the selected lane, or all four when broadcasting.
- Pop of lane k: the cycle where out_valid[k] & out_ready[k].
  - At the edge, lane_count[k] increments by 1, wrapping 2^CNT_WIDTH-1 -> 0.
  - Counter width is fixed; no saturation.
- Per-lane update at the clock edge:
  - Push only: register loads in_data, out_valid[k] -> 1.
  - Pop only: out_valid[k] -> 0; register keeps its old value (don't-care for consumers).
  - Push and pop together: register loads the new word, out_valid[k] stays 1, counter increments. Full throughput is 1 word/cycle/lane.
  - Neither: hold.
- Latency: a word accepted at edge N appears on its lane with out_valid high after edge N, i.e. 1 cycle.
- Broadcast is all-or-nothing: no lane loads unless every lane can take the word.
- in_valid=0 or in_ready=0: no lane loads, regardless of in_sel/in_bcast.
- in_data, in_sel and in_bcast must be stable only when in_valid=1. The producer may change them while stalled; the router never latches a word without in_ready.
- Lanes are independent. A stalled lane blocks the input only when it is the target or a broadcast is requested.

Test Plan:
- Reset then unicast: rst pulse; in_valid=1, sel=2, data=0x1234, out_ready=0 -> next cycle out_valid=0100, out_c=0x1234, lane_count=0; in_ready=0 for sel=2 and =1 for sel=0.
- Pop and count: out_ready[2]=1 one cycle -> out_valid[2]=0 next edge, lane_count[23:16]=1; others 0.
- Streaming: sel=1, out_ready[1]=1 held, data 0x0001..0x0010 on 16 consecutive cycles -> in_ready stays 1, out_b follows input 1 cycle late, lane_count[15:8]=16 after drain.
- Broadcast block: lane d full with out_ready[3]=0, bcast=1, data=0xBEEF -> in_ready=0, no lane changes. Raise out_ready[3] -> accept; next cycle all out_valid=1111, all outputs 0xBEEF, lane d count +1.
- Counter wrap: 256 pops on lane a -> lane_count[7:0] reads 255 after 255 pops, 0 after 256.
- Reset mid-operation: all lanes full, assert rst between edges -> out_valid=0000, outputs 0, counts 0 immediately (before next edge); in_ready=0 during rst.
